intensity: RTL and testbench
============================

INTENSITY -- requirements
Module: intensity

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 pixelData  input  216  3x3 window, nine 24-bit pixels; pixel k (k=0..8) occupies bits [215-24k : 192-24k].
REQ-005 pixelData: within each pixel, R = upper byte, G = middle byte, B = lower byte (pixel0: R[215:208], G[207:200], B[199:192]; pixel8: R[23:16], G[15:8], B[7:0]).
REQ-006 iGrid  output  72  nine 8-bit intensities; intensity k occupies bits [71-8k : 64-8k] (I0 = [71:64], I8 = [7:0]).
REQ-007 One clock; reset is asynchronous and active-low.

Function
REQ-008 Per pixel, unsigned: I = (77*R + 150*G + 29*B) >> 8 (floor, no rounding).
REQ-009 Weighted sum held at 16 bits minimum; max 256*255 = 65280 fits, so no overflow handling.
REQ-010 Result always fits 8 bits (0..255); no saturation logic; take bits [15:8] of the sum.
REQ-011 All nine lanes computed in parallel, identical arithmetic, no cross-lane interaction.
REQ-012 iGrid registered: value for pixelData sampled at rising edge N appears on iGrid after edge N; latency exactly 1 clock.
REQ-013 No enable or handshake: new input accepted every cycle; iGrid updates every rising edge while n_rst = 1.
REQ-014 Combinational input-to-register path; no combinational path from pixelData to iGrid.
REQ-015 Input held constant -> iGrid constant from the cycle after the first sampling edge.

Reset
REQ-016 n_rst = 0 immediately forces iGrid = 72'h0, independent of clk.
REQ-017 iGrid stays 0 while n_rst = 0, regardless of pixelData or clock edges.
REQ-018 After n_rst deasserts, first rising edge loads the intensity of the current pixelData.
REQ-019 Reset asserted mid-stream discards in-flight result; no state survives reset.

Verification
REQ-020 Reset: assert n_rst = 0 with nonzero pixelData between clock edges -> iGrid = 0 immediately, before the next edge.
REQ-021 Window test: pixel0 = (20,20,40), pixel1 = (60,80,100), pixel2 = (120,140,160), pixel3 = (12,24,48) -> one edge later I0 = 22, I1 = 76, I2 = 136, I3 = 23.
REQ-022 Extremes: all bytes 0 -> iGrid = 0; all bytes 255 -> every Ik = 255.
REQ-023 Primaries at full scale:
- (255,0,0) -> 76
- (0,255,0) -> 149
- (0,0,255) -> 28
Place each primary in a different lane to check lane ordering.
REQ-024 Back-to-back inputs: change pixelData every cycle (e.g. a permuted RGB ordering each cycle) -> each cycle's iGrid matches the previous cycle's input per REQ-008, with no skipped or stale results.

Source files
------------

// File: rtl/intensity.sv
// intensity: registered RGB-to-luma conversion for a 3x3 window of 24-bit pixels
module intensity (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [215:0] pixelData,
    output logic [71:0]  iGrid
);
    logic [71:0] igrid_d;
    logic [71:0] igrid_q;

    for (genvar g = 0; g < 9; g++) begin : g_lane
        logic [7:0]  r;
        logic [7:0]  gc;
        logic [7:0]  b;
        logic [15:0] sum;
        assign r   = pixelData[215-24*g -: 8];
        assign gc  = pixelData[207-24*g -: 8];
        assign b   = pixelData[199-24*g -: 8];
        // weights sum to 256, so the 16-bit sum never overflows and [15:8] is floor(sum/256)
        assign sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, gc} + 16'd29 * {8'd0, b};
        assign igrid_d[71-8*g -: 8] = sum[15:8];
    end

    // one-cycle output register, cleared asynchronously
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) igrid_q <= '0;
        else        igrid_q <= igrid_d;
    end

    assign iGrid = igrid_q;
endmodule

// File: tb/tb_intensity.sv
// tb_intensity: scoreboard bench for the intensity block
module tb_intensity;
    logic         clk = 1'b0;
    logic         n_rst;
    logic [215:0] pixelData;
    logic [71:0]  iGrid;
    int           checks = 0;
    int           errors = 0;
    logic [71:0]  sb[$];
    string        nq[$];

    always #5 clk = ~clk;

    intensity dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pixelData (pixelData),
        .iGrid     (iGrid)
    );

    // monitor: one registered result per active edge while out of reset
    always @(posedge clk) begin
        logic [71:0] e;
        string       nm;
        #1;
        if (n_rst === 1'b1 && sb.size() > 0) begin
            e  = sb.pop_front();
            nm = nq.pop_front();
            checks++;
            if (iGrid !== e) begin
                errors++;
                $display("FAIL %s: iGrid=%h expected=%h", nm, iGrid, e);
            end
        end
    end

    task automatic drive(input logic [215:0] d, input logic [71:0] e, input string nm);
        pixelData = d;
        sb.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [71:0] e);
        checks++;
        if (iGrid !== e) begin
            errors++;
            $display("FAIL %s: iGrid=%h expected=%h", nm, iGrid, e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results pending, expected 0", sb.size());
            sb.delete();
            nq.delete();
        end
    endtask

    initial begin
        n_rst     = 1'b0;
        pixelData = {9{24'h123456}};
        #2 chk("reset_async", 72'h0);
        repeat (2) @(posedge clk);
        #1 chk("reset_hold", 72'h0);
        @(negedge clk);
        n_rst = 1'b1;
        drive({24'h141428, 24'h3C5064, 24'h788CA0, 24'h0C1830, {5{24'h0}}},
              {8'd22, 8'd76, 8'd136, 8'd23, 40'h0}, "window");
        drive({24'h141428, 24'h3C5064, 24'h788CA0, 24'h0C1830, {5{24'h0}}},
              {8'd22, 8'd76, 8'd136, 8'd23, 40'h0}, "window_hold");
        drive(216'h0, 72'h0, "all_zero");
        drive({9{24'hFFFFFF}}, {9{8'hFF}}, "all_ones");
        drive({24'hFF0000, {3{24'h0}}, 24'h00FF00, {3{24'h0}}, 24'h0000FF},
              {8'd76, 24'h0, 8'd149, 24'h0, 8'd28}, "primaries");
        drive({{4{24'h14283C, 24'h0AC85A}}, 24'h14283C}, {{4{8'd36, 8'd130}}, 8'd36}, "perm_a");
        drive({{4{24'h283C14, 24'hC85A0A}}, 24'h283C14}, {{4{8'd49, 8'd114}}, 8'd49}, "perm_b");
        drive({{4{24'h3C1428, 24'h5A0AC8}}, 24'h3C1428}, {{4{8'd34, 8'd55}}, 8'd34}, "perm_c");
        drive({24'h0000FF, {3{24'h0}}, 24'hFF0000, {3{24'h0}}, 24'h00FF00},
              {8'd28, 24'h0, 8'd76, 24'h0, 8'd149}, "primaries_rot");
        drive({9{24'hFFFFFF}}, {9{8'hFF}}, "pre_reset");
        drain();
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1 chk("reset_mid", 72'h0);
        repeat (2) @(posedge clk);
        #1 chk("reset_mid_hold", 72'h0);
        @(negedge clk);
        n_rst = 1'b1;
        drive({24'h141428, 24'h3C5064, 24'h788CA0, 24'h0C1830, {5{24'h0}}},
              {8'd22, 8'd76, 8'd136, 8'd23, 40'h0}, "post_reset");
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
